selection_sort_param: RTL and testbench
=======================================

// Module: selection_sort_param
// PURPOSE
// - In-place selection sort of N words in an external single-port synchronous RAM.
// - Generalises the fixed 8-bit/11-entry sorter: configurable data/address width, length and base address.
// - Adds a per-run ascending/descending mode.
// - Sits between a control master (start/rdy/done handshake) and a RAM port with 1-cycle read latency.
// PARAMETERS
// - DATA_W  8   element width, unsigned compare
// - ADDR_W  8   RAM address width
// - N       11  elements to sort; legal range 1 <= N and BASE+N <= 2**ADDR_W
// - BASE    0   RAM address of element 0
// PORTS
// - clk      in   1       clock, rising edge
// - rst_n    in   1       asynchronous active-low reset
// - start    in   1       request a sort; accepted only while rdy=1
// - descend  in   1       0 = ascending, 1 = descending; sampled when start is accepted
// - rdy      out  1       idle, start will be accepted
// - done     out  1       one-cycle pulse when the sort completes
// - rddata   in   DATA_W  RAM read data, valid the cycle after addr is presented with wren=0
// - wrdata   out  DATA_W  RAM write data
// - addr     out  ADDR_W  RAM address
// - wren     out  1       RAM write enable; RAM writes wrdata to addr at this clk edge
// BEHAVIOUR
// - Reset (async on rst_n=0): state=IDLE, rdy=1, done=0, wren=0, addr=0, wrdata=0, all counters 0.
// - Reset mid-sort: abort immediately. RAM keeps the partially sorted contents; nothing is restored.
// - Mode is latched as desc_q at start. better(x,m) = desc_q ? (x > m) : (x < m).
//   Strict compare: an equal value never replaces the current extreme.
// - wren=1 only in WR_A and WR_B. addr = BASE + index. addr/wrdata hold their last value otherwise.
// - FSM:
//   IDLE:  rdy=1. If start: i=0, latch desc_q; N==1 -> DONE, else -> RD_I. start while rdy=0 is ignored.
//   RD_I:  addr=BASE+i                                   -> WT_I
//   WT_I:  cur_val=min_val=rddata, min_idx=i, j=i+1      -> RD_J
//   RD_J:  addr=BASE+j                                   -> CMP
//   CMP:   if better(rddata,min_val): min_val=rddata, min_idx=j.
//          If j==N-1 -> (min_idx!=i after the update ? WR_A : NEXT); else j++ -> RD_J.
//   WR_A:  addr=BASE+min_idx, wrdata=cur_val, wren=1     -> WR_B
//   WR_B:  addr=BASE+i, wrdata=min_val, wren=1           -> NEXT
//   NEXT:  if i==N-2 -> DONE, else i++                   -> RD_I
//   DONE:  done=1 for exactly one cycle, rdy=0           -> IDLE
// - Latency: outer pass i costs 3 + 2*(N-1-i) cycles, plus 2 if a swap occurs.
//   Add 1 cycle for DONE. N=1 completes in 1 cycle (IDLE->DONE).
// - Counters i, j, min_idx are ADDR_W bits wide and never wrap, given the N/BASE constraint.
// - rdy=0 from the cycle after start is accepted until DONE exits; rdy=1 again in the cycle after done.
// CONFIGURATION
// - SORT_STATS_EN defined: adds output port swap_cnt [ADDR_W-1:0].
//   Cleared when start is accepted; +1 on each WR_B; holds its value after done until the next start.
//   Reset value 0. Maximum value N-1.
// - SORT_STATS_EN undefined: the port and its logic are absent. Sorting behaviour is identical.
// TESTING
// - N=11, RAM={10,6,0,4,3,5,2,7,1,9,8}, descend=0, start 1 cycle
//   -> done pulses once; RAM={0,1,...,10}; rdy=1 the cycle after done.
// - Same RAM, descend=1 -> RAM={10,9,...,0}; with SORT_STATS_EN, swap_cnt equals the model's swap count.
// - N=11, RAM already ascending {0..10}, descend=0
//   -> wren never asserted; total cycles = sum over i of 3+2*(10-i), plus 1; swap_cnt=0.
// - RAM all 8'd5 -> no writes (strict compare); done pulses once.
// - start held high for the whole sort -> a single sort only; start re-accepted once rdy=1.
//   A second pulse mid-sort is ignored.
// - rst_n low during the 3rd outer pass -> next cycle rdy=1, done=0, wren=0.
//   A restarted sort completes with fully sorted RAM.
// - N=1, BASE=8'hF0 -> done the cycle after start; no RAM writes.

Source files
------------

// File: rtl/selection_sort_param.sv
// In-place selection sort of N words held in an external 1-cycle-latency RAM.
// Optional SORT_STATS_EN adds a swap_cnt output counting swaps in the last run.
module selection_sort_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int N      = 11,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              descend,
    output logic              rdy,
    output logic              done,
    input  logic [DATA_W-1:0] rddata,
    output logic [DATA_W-1:0] wrdata,
    output logic [ADDR_W-1:0] addr,
`ifdef SORT_STATS_EN
    output logic [ADDR_W-1:0] swap_cnt,
`endif
    output logic              wren
);
    typedef enum logic [3:0] {
        IDLE, RD_I, WT_I, RD_J, CMP, WR_A, WR_B, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(N - 2);

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_i, r_j, r_min_idx, r_addr, w_addr, w_new_idx;
    logic [DATA_W-1:0]   r_min_val, r_cur_val, r_wrdata, w_wrdata;
    logic                r_desc, w_better, w_wren;

    // Strict compare so equal values never displace the current extreme.
    assign w_better  = r_desc ? (rddata > r_min_val) : (rddata < r_min_val);
    assign w_new_idx = w_better ? r_j : r_min_idx;

    always_comb begin
        w_next   = r_state;
        w_addr   = r_addr;
        w_wrdata = r_wrdata;
        w_wren   = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = (N == 1) ? DONE : RD_I;
            RD_I: begin
                w_addr = BASE_A + r_i;
                w_next = WT_I;
            end
            WT_I: w_next = RD_J;
            RD_J: begin
                w_addr = BASE_A + r_j;
                w_next = CMP;
            end
            CMP: begin
                if (r_j == LAST_J) w_next = (w_new_idx != r_i) ? WR_A : NEXT;
                else               w_next = RD_J;
            end
            WR_A: begin
                w_addr   = BASE_A + r_min_idx;
                w_wrdata = r_cur_val;
                w_wren   = 1'b1;
                w_next   = WR_B;
            end
            WR_B: begin
                w_addr   = BASE_A + r_i;
                w_wrdata = r_min_val;
                w_wren   = 1'b1;
                w_next   = NEXT;
            end
            NEXT:    w_next = (r_i == LAST_I) ? DONE : RD_I;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Address/data are driven combinationally in their states and held otherwise.
    assign addr   = w_addr;
    assign wrdata = w_wrdata;
    assign wren   = w_wren;
    assign rdy    = (r_state == IDLE);
    assign done   = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_min_idx <= '0;
            r_min_val <= '0;
            r_cur_val <= '0;
            r_desc    <= 1'b0;
            r_addr    <= '0;
            r_wrdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_addr   <= w_addr;
            r_wrdata <= w_wrdata;
            case (r_state)
                IDLE: if (start) begin
                    r_i    <= '0;
                    r_desc <= descend;
                end
                WT_I: begin
                    r_cur_val <= rddata;
                    r_min_val <= rddata;
                    r_min_idx <= r_i;
                    r_j       <= r_i + 1'b1;
                end
                CMP: begin
                    if (w_better) begin
                        r_min_val <= rddata;
                        r_min_idx <= r_j;
                    end
                    if (r_j != LAST_J) r_j <= r_j + 1'b1;
                end
                NEXT: if (r_i != LAST_I) r_i <= r_i + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SORT_STATS_EN
    logic [ADDR_W-1:0] r_swap_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_swap_cnt <= '0;
        else if (r_state == IDLE && start) r_swap_cnt <= '0;
        else if (r_state == WR_B)          r_swap_cnt <= r_swap_cnt + 1'b1;
    end
    assign swap_cnt = r_swap_cnt;
`endif
endmodule

// File: tb/tb_selection_sort_param.sv
// Directed bench for selection_sort_param: N=11 sorter plus an N=1/BASE=F0 instance.
module tb_selection_sort_param;
    localparam logic [0:10][7:0] V_MIX  = '{8'd10, 8'd6, 8'd0, 8'd4, 8'd3, 8'd5, 8'd2, 8'd7, 8'd1, 8'd9, 8'd8};
    localparam logic [0:10][7:0] V_ASC  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    localparam logic [0:10][7:0] V_FIVE = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       start = 1'b0, descend = 1'b0, rdy, done, wren;
    logic [7:0] rddata, wrdata, addr;
    logic       start1 = 1'b0, descend1 = 1'b0, rdy1, done1, wren1;
    logic [7:0] rddata1, wrdata1, addr1;
`ifdef SORT_STATS_EN
    logic [7:0] swap_cnt, swap_cnt1;
`endif

    selection_sort_param #(.DATA_W(8), .ADDR_W(8), .N(11), .BASE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .descend(descend), .rdy(rdy), .done(done),
        .rddata(rddata), .wrdata(wrdata), .addr(addr),
`ifdef SORT_STATS_EN
        .swap_cnt(swap_cnt),
`endif
        .wren(wren));

    selection_sort_param #(.DATA_W(8), .ADDR_W(8), .N(1), .BASE(8'hF0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .descend(descend1), .rdy(rdy1), .done(done1),
        .rddata(rddata1), .wrdata(wrdata1), .addr(addr1),
`ifdef SORT_STATS_EN
        .swap_cnt(swap_cnt1),
`endif
        .wren(wren1));

    // RAM models with a bench-side load port
    logic [7:0] mem [256];
    logic [7:0] mem1 [256];
    logic       ld_en = 1'b0, ld_en1 = 1'b0;
    logic [7:0] ld_addr = '0, ld_data = '0, ld_addr1 = '0, ld_data1 = '0;

    always @(posedge clk) begin
        if (ld_en)     mem[ld_addr] <= ld_data;
        else if (wren) mem[addr]    <= wrdata;
        rddata <= mem[addr];
        if (ld_en1)     mem1[ld_addr1] <= ld_data1;
        else if (wren1) mem1[addr1]    <= wrdata1;
        rddata1 <= mem1[addr1];
    end

    int wr_cnt = 0, done_cnt = 0, wr_cnt1 = 0, done_cnt1 = 0;
    always @(negedge clk) begin
        if (wren)  wr_cnt    <= wr_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
        if (wren1) wr_cnt1   <= wr_cnt1 + 1;
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    int n_cmp = 0, n_err = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [0:10][7:0] v);
        for (int k = 0; k < 11; k++) begin
            ld_en = 1'b1; ld_addr = 8'(k); ld_data = v[k];
            tick();
        end
        ld_en = 1'b0;
    endtask

    // Pulses start, waits (bounded) for done, and reports cycles, writes, done pulses, rdy after.
    task automatic run_sort(input logic d, output int cyc, output int nwr, output int ndone,
                            output logic rdy_after);
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        descend = d; start = 1'b1;
        tick();
        start = 1'b0; cyc = 1;
        while (!done && cyc < 2000) begin tick(); cyc++; end
        tick();
        rdy_after = rdy;
        nwr = wr_cnt - w0; ndone = done_cnt - d0;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if (rdy !== 1'b1)   begin n_err++; $display("FAIL reset_rdy got %0b want 1", rdy); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (wren !== 1'b0)  begin n_err++; $display("FAIL reset_wren got %0b want 0", wren); end
        n_cmp++; if (addr !== 8'd0)  begin n_err++; $display("FAIL reset_addr got %0d want 0", addr); end
        n_cmp++; if (wrdata !== 8'd0) begin n_err++; $display("FAIL reset_wrdata got %0d want 0", wrdata); end
        n_cmp++; if (rdy1 !== 1'b1)  begin n_err++; $display("FAIL reset_rdy1 got %0b want 1", rdy1); end
`ifdef SORT_STATS_EN
        n_cmp++; if (swap_cnt !== 8'd0) begin n_err++; $display("FAIL reset_swap got %0d want 0", swap_cnt); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ascend();
        int c, w, dn; logic ra;
        load(V_MIX);
        run_sort(1'b0, c, w, dn, ra);
        n_cmp++; if (c != 153)   begin n_err++; $display("FAIL asc_cycles got %0d want 153", c); end
        n_cmp++; if (w != 12)    begin n_err++; $display("FAIL asc_writes got %0d want 12", w); end
        n_cmp++; if (dn != 1)    begin n_err++; $display("FAIL asc_done_pulses got %0d want 1", dn); end
        n_cmp++; if (ra !== 1'b1) begin n_err++; $display("FAIL asc_rdy_after got %0b want 1", ra); end
        for (int k = 0; k < 11; k++) begin
            n_cmp++;
            if (mem[k] !== V_ASC[k]) begin n_err++; $display("FAIL asc_mem[%0d] got %0d want %0d", k, mem[k], V_ASC[k]); end
        end
`ifdef SORT_STATS_EN
        n_cmp++; if (swap_cnt !== 8'd6) begin n_err++; $display("FAIL asc_swap got %0d want 6", swap_cnt); end
`endif
    endtask

    task automatic test_descend();
        int c, w, dn; logic ra;
        load(V_MIX);
        run_sort(1'b1, c, w, dn, ra);
        n_cmp++; if (c != 155) begin n_err++; $display("FAIL desc_cycles got %0d want 155", c); end
        n_cmp++; if (w != 14)  begin n_err++; $display("FAIL desc_writes got %0d want 14", w); end
        n_cmp++; if (dn != 1)  begin n_err++; $display("FAIL desc_done_pulses got %0d want 1", dn); end
        for (int k = 0; k < 11; k++) begin
            n_cmp++;
            if (mem[k] !== V_ASC[10-k]) begin n_err++; $display("FAIL desc_mem[%0d] got %0d want %0d", k, mem[k], V_ASC[10-k]); end
        end
`ifdef SORT_STATS_EN
        n_cmp++; if (swap_cnt !== 8'd7) begin n_err++; $display("FAIL desc_swap got %0d want 7", swap_cnt); end
`endif
    endtask

    task automatic test_presorted();
        int c, w, dn; logic ra;
        load(V_ASC);
        run_sort(1'b0, c, w, dn, ra);
        n_cmp++; if (c != 141) begin n_err++; $display("FAIL sorted_cycles got %0d want 141", c); end
        n_cmp++; if (w != 0)   begin n_err++; $display("FAIL sorted_writes got %0d want 0", w); end
`ifdef SORT_STATS_EN
        n_cmp++; if (swap_cnt !== 8'd0) begin n_err++; $display("FAIL sorted_swap got %0d want 0", swap_cnt); end
`endif
    endtask

    task automatic test_equal();
        int c, w, dn; logic ra; int bad;
        load(V_FIVE);
        run_sort(1'b0, c, w, dn, ra);
        n_cmp++; if (w != 0)   begin n_err++; $display("FAIL equal_writes got %0d want 0", w); end
        n_cmp++; if (dn != 1)  begin n_err++; $display("FAIL equal_done_pulses got %0d want 1", dn); end
        n_cmp++; if (c != 141) begin n_err++; $display("FAIL equal_cycles got %0d want 141", c); end
        bad = 0;
        for (int k = 0; k < 11; k++) if (mem[k] !== 8'd5) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL equal_mem got %0d changed words want 0", bad); end
    endtask

    task automatic test_start_held();
        int c, d0;
        load(V_MIX);
        d0 = done_cnt;
        descend = 1'b0; start = 1'b1;
        tick(); c = 1;
        while (!done && c < 2000) begin tick(); c++; end
        n_cmp++; if (c != 153) begin n_err++; $display("FAIL held_cycles got %0d want 153", c); end
        tick();
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL held_rdy_after_done got %0b want 1", rdy); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL held_done_pulses got %0d want 1", done_cnt - d0); end
        tick();
        n_cmp++; if (rdy !== 1'b0) begin n_err++; $display("FAIL held_reaccept_rdy got %0b want 0", rdy); end
        start = 1'b0; c = 1;
        while (!done && c < 2000) begin tick(); c++; end
        n_cmp++; if (c != 141) begin n_err++; $display("FAIL held_second_cycles got %0d want 141", c); end
        tick();
    endtask

    task automatic test_mid_pulse();
        int c, d0;
        load(V_MIX);
        d0 = done_cnt;
        descend = 1'b0; start = 1'b1;
        tick(); start = 1'b0; c = 1;
        while (!done && c < 2000) begin
            start = (c == 20);
            tick(); c++;
        end
        start = 1'b0;
        n_cmp++; if (c != 153) begin n_err++; $display("FAIL pulse_cycles got %0d want 153", c); end
        repeat (3) tick();
        n_cmp++; if (rdy !== 1'b1) begin n_err++; $display("FAIL pulse_idle_rdy got %0b want 1", rdy); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL pulse_done_pulses got %0d want 1", done_cnt - d0); end
        n_cmp++; if (mem[10] !== 8'd10) begin n_err++; $display("FAIL pulse_mem10 got %0d want 10", mem[10]); end
    endtask

    task automatic test_reset_mid();
        int c, w, dn, w0, n; logic ra;
        load(V_MIX);
        w0 = wr_cnt;
        descend = 1'b0; start = 1'b1;
        tick(); start = 1'b0; n = 0;
        while (wr_cnt - w0 < 4 && n < 500) begin tick(); n++; end
        n_cmp++; if (wr_cnt - w0 != 4) begin n_err++; $display("FAIL rstmid_writes_before got %0d want 4", wr_cnt - w0); end
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rdy !== 1'b1)  begin n_err++; $display("FAIL rstmid_rdy got %0b want 1", rdy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %0b want 0", done); end
        n_cmp++; if (wren !== 1'b0) begin n_err++; $display("FAIL rstmid_wren got %0b want 0", wren); end
        tick(); rst_n = 1'b1; tick();
        n_cmp++; if (mem[1] !== 8'd1)  begin n_err++; $display("FAIL rstmid_partial1 got %0d want 1", mem[1]); end
        n_cmp++; if (mem[2] !== 8'd10) begin n_err++; $display("FAIL rstmid_partial2 got %0d want 10", mem[2]); end
        run_sort(1'b0, c, w, dn, ra);
        n_cmp++; if (w != 8) begin n_err++; $display("FAIL rstmid_rerun_writes got %0d want 8", w); end
        for (int k = 0; k < 11; k++) begin
            n_cmp++;
            if (mem[k] !== V_ASC[k]) begin n_err++; $display("FAIL rstmid_mem[%0d] got %0d want %0d", k, mem[k], V_ASC[k]); end
        end
    endtask

    task automatic test_n1();
        int w0, d0;
        ld_en1 = 1'b1; ld_addr1 = 8'hF0; ld_data1 = 8'h42;
        tick(); ld_en1 = 1'b0;
        w0 = wr_cnt1; d0 = done_cnt1;
        start1 = 1'b1;
        tick(); start1 = 1'b0;
        n_cmp++; if (done1 !== 1'b1) begin n_err++; $display("FAIL n1_done got %0b want 1", done1); end
        tick();
        n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL n1_rdy_after got %0b want 1", rdy1); end
        n_cmp++; if (wr_cnt1 - w0 != 0) begin n_err++; $display("FAIL n1_writes got %0d want 0", wr_cnt1 - w0); end
        n_cmp++; if (done_cnt1 - d0 != 1) begin n_err++; $display("FAIL n1_done_pulses got %0d want 1", done_cnt1 - d0); end
        n_cmp++; if (mem1[8'hF0] !== 8'h42) begin n_err++; $display("FAIL n1_mem got %0h want 42", mem1[8'hF0]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ascend();
        test_descend();
        test_presorted();
        test_equal();
        test_start_held();
        test_mid_pulse();
        test_reset_mid();
        test_n1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
